// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder: FSM states, the {b,a}
// phase table in forward order, and the edges-per-revolution helper.
package quad_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // {b,a} phase codes listed in forward (A leads B) order
    localparam logic [1:0] PH_0 = 2'b00;
    localparam logic [1:0] PH_1 = 2'b01;
    localparam logic [1:0] PH_2 = 2'b11;
    localparam logic [1:0] PH_3 = 2'b10;

    function automatic int edges_per_rev(input int ppr);
        return 4 * ppr;
    endfunction

    function automatic logic [1:0] phase_next(input logic [1:0] ph, input logic fwd);
        logic [1:0] nxt;
        nxt = PH_0;
        case (ph)
            PH_0:    nxt = fwd ? PH_1 : PH_3;
            PH_1:    nxt = fwd ? PH_2 : PH_0;
            PH_2:    nxt = fwd ? PH_3 : PH_1;
            default: nxt = fwd ? PH_0 : PH_2;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_phase_seq.sv
// Gray-code quadrature stepper with an edge position counter that wraps
// modulo one revolution. One edge per cycle in which step is high.
module quad_phase_seq
    import quad_pkg::*;
#(
    parameter int PPR = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic                         dir,
    output logic                         a,
    output logic                         b,
    output logic [$clog2(4*PPR)-1:0]     edge_pos
);

    localparam int EPR   = edges_per_rev(PPR);
    localparam int POS_W = $clog2(EPR);

    always_ff @(posedge clk) begin
        if (rst) begin
            {b, a}   <= PH_0;
            edge_pos <= '0;
        end else if (step) begin
            {b, a} <= phase_next({b, a}, dir);
            if (dir)
                edge_pos <= (edge_pos == POS_W'(EPR - 1)) ? '0 : edge_pos + POS_W'(1);
            else
                edge_pos <= (edge_pos == '0) ? POS_W'(EPR - 1) : edge_pos - POS_W'(1);
        end
    end

endmodule

// File: rtl/quadrature_encoder.sv
// Quadrature pulse generator: executes signed move commands as timed A/B edges.
// Optional index output z is enabled by defining QUAD_ENC_INDEX_EN.
module quadrature_encoder
    import quad_pkg::*;
#(
    parameter int PPR        = 4,
    parameter int CNT_W      = 16,
    parameter int PER_W      = 16,
    parameter int MIN_PERIOD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic signed [CNT_W-1:0]     cmd_steps,
    input  logic [PER_W-1:0]            cmd_period,
    input  logic                        abort,
    output logic                        a,
    output logic                        b,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic [$clog2(4*PPR)-1:0]    edge_pos,
    output logic                        z
);

    localparam int EPR   = edges_per_rev(PPR);
    localparam int POS_W = $clog2(EPR);

    state_t             state, state_next;
    logic [PER_W-1:0]   timer, timer_next;
    logic [PER_W-1:0]   period, period_next;
    logic [CNT_W-1:0]   remaining, remaining_next;
    logic               fwd, fwd_next;
    logic               step;
    logic               done_next, aborted_next;
    logic [CNT_W-1:0]   steps_u, steps_mag;
    logic [PER_W-1:0]   period_clamped;

    // Magnitude kept unsigned so the most negative count maps to 2^(CNT_W-1)
    assign steps_u        = cmd_steps;
    assign steps_mag      = steps_u[CNT_W-1] ? (~steps_u + CNT_W'(1)) : steps_u;
    assign period_clamped = (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;

    always_comb begin
        state_next     = state;
        timer_next     = timer;
        period_next    = period;
        remaining_next = remaining;
        fwd_next       = fwd;
        step           = 1'b0;
        done_next      = 1'b0;
        aborted_next   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    fwd_next       = ~cmd_steps[CNT_W-1];
                    period_next    = period_clamped;
                    remaining_next = steps_mag;
                    // First edge lands P cycles after accept, later ones every P
                    timer_next     = period_clamped - PER_W'(1);
                    if (steps_mag == '0)
                        done_next = 1'b1;
                    else
                        state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (timer == PER_W'(1)) begin
                    step           = 1'b1;
                    timer_next     = period;
                    remaining_next = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    timer_next = timer - PER_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == IDLE);
            busy      <= (state_next == RUN);
            done      <= done_next;
            aborted   <= aborted_next;
        end
    end

    always_ff @(posedge clk) begin
        timer     <= timer_next;
        period    <= period_next;
        remaining <= remaining_next;
        fwd       <= fwd_next;
    end

    quad_phase_seq #(
        .PPR(PPR)
    ) u_phase_seq (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .dir      (fwd),
        .a        (a),
        .b        (b),
        .edge_pos (edge_pos)
    );

`ifdef QUAD_ENC_INDEX_EN
    logic lands_zero;

    // Index updates only on edges, so it marks arrival at the zero position
    assign lands_zero = (phase_next({b, a}, fwd) == PH_0) &&
                        (fwd ? (edge_pos == POS_W'(EPR - 1)) : (edge_pos == POS_W'(1)));

    always_ff @(posedge clk) begin
        if (rst)
            z <= 1'b0;
        else if (step)
            z <= lands_zero;
    end
`else
    assign z = 1'b0;
`endif

endmodule

// File: tb/tb_quadrature_encoder.sv
// Self-checking bench for quadrature_encoder: table of directed moves, hand
// sequences for reset/abort corners, and randomized moves against a move model.
module tb_quadrature_encoder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic signed [15:0] cmd_steps = '0;
    logic [15:0]        cmd_period = '0;
    logic               abort = 1'b0;
    logic               a, b, busy, done, aborted, z;
    logic [3:0]         edge_pos;

    int checks = 0;
    int errors = 0;

    // Model of position carried between moves
    int m_pos = 0;
    int m_ph  = 0;
    int m_z   = 0;
    logic [1:0] ph_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    int   jumps = 0;
    int   z_rises = 0;
    logic [1:0] ba_prev = 2'b00;
    logic z_prev = 1'b0;
    logic rst_prev = 1'b1;

    quadrature_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .edge_pos   (edge_pos),
        .z          (z)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_prev && (({b, a} ^ ba_prev) == 2'b11)) jumps++;
        if (z && !z_prev) z_rises++;
        ba_prev  = {b, a};
        z_prev   = z;
        rst_prev = rst;
    end

    function automatic int md(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    function automatic int pack(input bit zz, input bit rdy, input bit ab, input bit dn,
                                input bit bs, input bit bb, input bit aa, input int pos);
        logic [3:0] p4;
        p4 = pos[3:0];
        return int'({zz, rdy, ab, dn, bs, bb, aa, p4});
    endfunction

    function automatic int dut_vec();
        return pack(z, cmd_ready, aborted, done, busy, b, a, int'(edge_pos));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", dut_vec(), pack(0, 1, 0, 0, 0, 0, 0, 0));
        m_pos = 0; m_ph = 0; m_z = 0;
    endtask

    task automatic drive_cmd(input int steps, input int period);
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_period = 16'(period);
    endtask

    // Follows one move from its accept cycle T0 to its end cycle, comparing
    // every cycle with the edge-count model; returns the offset of DUT done.
    task automatic track_move(input int steps, input int period, input int ab_off,
                              input bit chain, input int nsteps, input int nperiod,
                              input bit here, output int done_off);
        int n, dir, p, eoff, ecap, e, pos_e, ph_e, z_e;
        bit ab, got;
        done_off = -1;
        if (!here) begin
            got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                got = cmd_ready;
            end
            if (!got) begin
                chk("accept_wait", int'(cmd_ready), 1);
                return;
            end
        end
        n    = (steps < 0) ? -steps : steps;
        dir  = (steps < 0) ? -1 : 1;
        p    = (period < 4) ? 4 : period;
        ab   = 1'b0;
        ecap = n;
        eoff = n * p;
        if (n == 0) begin
            eoff = 1; ecap = 0;
        end else if (ab_off >= 1 && ab_off <= n * p - 1) begin
            ab = 1'b1; eoff = ab_off + 1; ecap = ab_off / p;
        end
        z_e = m_z;
        for (int d = 1; d <= eoff; d++) begin
            @(posedge clk); #1;
            if (d == 1) begin
                if (chain) begin
                    cmd_steps  = 16'(nsteps);
                    cmd_period = 16'(nperiod);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            abort = ab && (d == ab_off);
            @(negedge clk);
            e = d / p;
            if (e > ecap) e = ecap;
            pos_e = md(m_pos + dir * e, 16);
            ph_e  = md(m_ph + dir * e, 4);
`ifdef QUAD_ENC_INDEX_EN
            z_e = (e > 0) ? int'(pos_e == 0) : m_z;
`else
            z_e = 0;
`endif
            chk("move_cycle", dut_vec(),
                pack(z_e[0], d >= eoff, ab && d == eoff, d == eoff, d < eoff,
                     ph_tab[ph_e][1], ph_tab[ph_e][0], pos_e));
            if (done && done_off < 0) done_off = d;
        end
        m_pos = md(m_pos + dir * ecap, 16);
        m_ph  = md(m_ph + dir * ecap, 4);
        m_z   = z_e;
    endtask

    typedef struct {
        bit rst_before;
        int steps;
        int period;
        int ab_off;
        int exp_end;
        int exp_ba;
        int exp_pos;
        int exp_ab;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int done_off, n, p, ab_off, steps, period, nsteps, nperiod, zbase;
        bit chain;

        tbl[0] = '{1,      8, 10, -1, 80, 0,  8, 0};
        tbl[1] = '{1,     -3,  5, -1, 15, 1, 13, 0};
        tbl[2] = '{0,      2,  1, -1,  8, 2, 15, 0};
        tbl[3] = '{0,      0,  7, -1,  1, 2, 15, 0};
        tbl[4] = '{0,      5,  6, 14, 15, 1,  1, 1};
        tbl[5] = '{0, -32768,  4, 10, 11, 2, 15, 1};
        tbl[6] = '{0,      3,  5, 14, 15, 1,  1, 1};
        tbl[7] = '{0,      1,  4, -1,  4, 3,  2, 0};

        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst_before) do_reset();
            drive_cmd(tbl[i].steps, tbl[i].period);
            track_move(tbl[i].steps, tbl[i].period, tbl[i].ab_off, 1'b0, 0, 0, 1'b0, done_off);
            chk($sformatf("row%0d_done_off", i), done_off, tbl[i].exp_end);
            chk($sformatf("row%0d_ba", i), int'({b, a}), tbl[i].exp_ba);
            chk($sformatf("row%0d_pos", i), int'(edge_pos), tbl[i].exp_pos);
            chk($sformatf("row%0d_aborted", i), int'(aborted), tbl[i].exp_ab);
        end

        // abort while idle has no effect
        @(posedge clk); #1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_abort", dut_vec(),
                pack(m_z[0], 1, 0, 0, 0, ph_tab[m_ph][1], ph_tab[m_ph][0], m_pos));
        end
        @(posedge clk); #1;
        abort = 1'b0;

        // back-to-back: second command held valid through the first move
        drive_cmd(4, 5);
        track_move(4, 5, -1, 1'b1, -3, 7, 1'b0, done_off);
        chk("b2b_first_done", done_off, 20);
        track_move(-3, 7, -1, 1'b0, 0, 0, 1'b1, done_off);
        chk("b2b_second_done", done_off, 21);

        // reset in the middle of a move drops it with no further activity
        drive_cmd(5, 6);
        track_move(5, 6, -1, 1'b0, 0, 0, 1'b0, done_off);
        drive_cmd(5, 6);
        begin
            bit got;
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                got = cmd_ready;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            repeat (7) @(posedge clk);
        end
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("after_rst_idle", dut_vec(), pack(0, 1, 0, 0, 0, 0, 0, 0));
        end

        // one revolution boundary crossed twice
        do_reset();
        zbase = z_rises;
        drive_cmd(32, 4);
        track_move(32, 4, -1, 1'b0, 0, 0, 1'b0, done_off);
`ifdef QUAD_ENC_INDEX_EN
        chk("z_pulses", z_rises - zbase, 2);
`else
        chk("z_pulses", z_rises - zbase, 0);
`endif

        // randomized moves, optional abort, idle gaps and chained commands
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            steps  = int'($urandom_range(0, 24)) - 12;
            period = $urandom_range(0, 9);
            n      = (steps < 0) ? -steps : steps;
            p      = (period < 4) ? 4 : period;
            ab_off = -1;
            chain  = ($urandom_range(0, 9) < 3);
            if (n > 0 && $urandom_range(0, 3) == 0 && !chain)
                ab_off = $urandom_range(1, n * p - 1);
            nsteps  = int'($urandom_range(0, 16)) - 8;
            nperiod = $urandom_range(0, 8);
            drive_cmd(steps, period);
            abort = 1'($urandom_range(0, 1));
            track_move(steps, period, ab_off, chain, nsteps, nperiod, 1'b0, done_off);
            if (chain)
                track_move(nsteps, nperiod, -1, 1'b0, 0, 0, 1'b1, done_off);
        end

        chk("gray_jumps", jumps, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
